// File: rtl/audio_stream_pkg.sv
// Shared types and width-conversion helpers for the stereo codec sample bridge.
// Samples are carried as left-justified values inside the 24-bit codec word.
package audio_stream_pkg;

    localparam int CODEC_W = 24;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    // User sample (right-aligned in a codec word) -> codec word with zero LSBs.
    function automatic logic [CODEC_W-1:0] pad_sample(input logic [CODEC_W-1:0] sample,
                                                      input int width);
        return sample << (CODEC_W - width);
    endfunction

    // Codec word -> user sample right-aligned; LSBs are dropped, never rounded.
    function automatic logic [CODEC_W-1:0] trunc_sample(input logic [CODEC_W-1:0] word,
                                                        input int width);
        return word >> (CODEC_W - width);
    endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with show-ahead output and registered full/empty/level.
// Pushes while full and pops while empty are ignored.
module audio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [AW:0]      w_level_next;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~r_full;
    assign w_pop  = pop & ~r_empty;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_next;
            r_full  <= (w_level_next == (AW+1)'(DEPTH));
            r_empty <= (w_level_next == '0);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;

endmodule

// File: rtl/audio_stream_bridge.sv
// Valid/ready stereo sample bridge to the codec core: TX/RX FIFOs, one transfer
// per codec frame, underrun policy, sticky error flags, frame counter, loopback.
module audio_stream_bridge
    import audio_stream_pkg::*;
#(
    parameter int SAMPLE_W      = 24,
    parameter int FIFO_DEPTH    = 16,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [2*SAMPLE_W-1:0]         tx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [2*SAMPLE_W-1:0]         rx_data,
    input  logic                          loopback,
    input  logic                          clear_flags,
    output logic                          overflow,
    output logic                          underrun,
    output logic                          frame_strobe,
    output logic [15:0]                   frame_count,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    input  logic                          codec_read_ready,
    input  logic                          codec_write_ready,
    input  logic [CODEC_W-1:0]            codec_adc_left,
    input  logic [CODEC_W-1:0]            codec_adc_right,
    output logic                          codec_read,
    output logic                          codec_write,
    output logic [CODEC_W-1:0]            codec_dac_left,
    output logic [CODEC_W-1:0]            codec_dac_right
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_start;
    logic                 w_xfer;

    logic [CODEC_W-1:0]   r_dac_left;
    logic [CODEC_W-1:0]   r_dac_right;
    logic [CODEC_W-1:0]   r_last_left;
    logic [CODEC_W-1:0]   r_last_right;
    logic [15:0]          r_frame_count;
    logic                 r_overflow;
    logic                 r_underrun;

    logic [2*SAMPLE_W-1:0] w_tx_dout;
    logic [2*SAMPLE_W-1:0] w_rx_din;
    logic                 w_tx_full;
    logic                 w_tx_empty;
    logic                 w_tx_pop;
    logic                 w_rx_full;
    logic                 w_rx_empty;
    logic                 w_rx_push;
    logic                 w_underrun_set;
    logic                 w_overflow_set;

    // Channel index 1 is left, 0 is right, matching the {left,right} packing.
    logic [CODEC_W-1:0]   w_adc_ch  [2];
    logic [CODEC_W-1:0]   w_last_ch [2];
    logic [CODEC_W-1:0]   w_tx_pad  [2];
    logic [CODEC_W-1:0]   w_lb_pad  [2];

    assign w_adc_ch[1]  = codec_adc_left;
    assign w_adc_ch[0]  = codec_adc_right;
    assign w_last_ch[1] = r_last_left;
    assign w_last_ch[0] = r_last_right;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign w_rx_din[gi*SAMPLE_W +: SAMPLE_W] =
                SAMPLE_W'(trunc_sample(w_adc_ch[gi], SAMPLE_W));
            assign w_tx_pad[gi] =
                pad_sample(CODEC_W'(w_tx_dout[gi*SAMPLE_W +: SAMPLE_W]), SAMPLE_W);
            assign w_lb_pad[gi] =
                pad_sample(CODEC_W'(SAMPLE_W'(trunc_sample(w_last_ch[gi], SAMPLE_W))), SAMPLE_W);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            IDLE: begin
                if (codec_read_ready && codec_write_ready) begin
                    w_state_next = XFER;
                    w_start      = 1'b1;
                end
            end
            XFER: begin
                w_xfer       = 1'b1;
                w_state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                // Readies must fall before another frame can start.
                if (!codec_read_ready || !codec_write_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_tx_pop       = w_start & ~loopback & ~w_tx_empty;
    assign w_underrun_set = w_start & ~loopback & w_tx_empty;
    assign w_rx_push      = w_xfer & ~w_rx_full;
    assign w_overflow_set = w_xfer & w_rx_full;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_dac_left    <= '0;
            r_dac_right   <= '0;
            r_last_left   <= '0;
            r_last_right  <= '0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                if (loopback) begin
                    r_dac_left  <= w_lb_pad[1];
                    r_dac_right <= w_lb_pad[0];
                end else if (!w_tx_empty) begin
                    r_dac_left  <= w_tx_pad[1];
                    r_dac_right <= w_tx_pad[0];
                end else if (UNDERRUN_HOLD == 0) begin
                    r_dac_left  <= '0;
                    r_dac_right <= '0;
                end
            end
            if (w_xfer) begin
                r_last_left   <= codec_adc_left;
                r_last_right  <= codec_adc_right;
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_underrun_set)   r_underrun <= 1'b1;
            else if (clear_flags) r_underrun <= 1'b0;
            if (w_overflow_set)   r_overflow <= 1'b1;
            else if (clear_flags) r_overflow <= 1'b0;
        end
    end

    audio_sync_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (tx_valid),
        .pop   (w_tx_pop),
        .din   (tx_data),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .level (tx_level)
    );

    audio_sync_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (w_rx_push),
        .pop   (rx_ready),
        .din   (w_rx_din),
        .dout  (rx_data),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (rx_level)
    );

    assign tx_ready        = ~w_tx_full;
    assign rx_valid        = ~w_rx_empty;
    assign codec_read      = w_xfer;
    assign codec_write     = w_xfer;
    assign frame_strobe    = w_xfer;
    assign codec_dac_left  = r_dac_left;
    assign codec_dac_right = r_dac_right;
    assign frame_count     = r_frame_count;
    assign overflow        = r_overflow;
    assign underrun        = r_underrun;

endmodule

// File: tb/tb_audio_stream_bridge.sv
// Bench for audio_stream_bridge at SAMPLE_W=16, depth 16, with one instance per
// underrun policy; a queue-based frame model supplies all expected values.
module tb_audio_stream_bridge;

    localparam int SW    = 16;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          tx_valid = 1'b0, rx_ready = 1'b0, loopback = 1'b0, clear_flags = 1'b0;
    logic          rd_rdy = 1'b0, wr_rdy = 1'b0;
    logic [31:0]   tx_data = '0;
    logic [23:0]   adc_l = '0, adc_r = '0;

    logic          h_tx_ready, h_rx_valid, h_overflow, h_underrun, h_strobe, h_read, h_write;
    logic [31:0]   h_rx_data;
    logic [15:0]   h_count;
    logic [LW-1:0] h_tx_level, h_rx_level;
    logic [23:0]   h_dac_l, h_dac_r;
    logic          z_tx_ready, z_rx_valid, z_overflow, z_underrun, z_strobe, z_read, z_write;
    logic [31:0]   z_rx_data;
    logic [15:0]   z_count;
    logic [LW-1:0] z_tx_level, z_rx_level;
    logic [23:0]   z_dac_l, z_dac_r;

    audio_stream_bridge #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .UNDERRUN_HOLD(1)) dut_h (
        .CLOCK_50(clk), .reset(rst), .tx_valid(tx_valid), .tx_ready(h_tx_ready),
        .tx_data(tx_data), .rx_valid(h_rx_valid), .rx_ready(rx_ready), .rx_data(h_rx_data),
        .loopback(loopback), .clear_flags(clear_flags), .overflow(h_overflow),
        .underrun(h_underrun), .frame_strobe(h_strobe), .frame_count(h_count),
        .tx_level(h_tx_level), .rx_level(h_rx_level), .codec_read_ready(rd_rdy),
        .codec_write_ready(wr_rdy), .codec_adc_left(adc_l), .codec_adc_right(adc_r),
        .codec_read(h_read), .codec_write(h_write), .codec_dac_left(h_dac_l),
        .codec_dac_right(h_dac_r));

    audio_stream_bridge #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .UNDERRUN_HOLD(0)) dut_z (
        .CLOCK_50(clk), .reset(rst), .tx_valid(tx_valid), .tx_ready(z_tx_ready),
        .tx_data(tx_data), .rx_valid(z_rx_valid), .rx_ready(rx_ready), .rx_data(z_rx_data),
        .loopback(loopback), .clear_flags(clear_flags), .overflow(z_overflow),
        .underrun(z_underrun), .frame_strobe(z_strobe), .frame_count(z_count),
        .tx_level(z_tx_level), .rx_level(z_rx_level), .codec_read_ready(rd_rdy),
        .codec_write_ready(wr_rdy), .codec_adc_left(adc_l), .codec_adc_right(adc_r),
        .codec_read(z_read), .codec_write(z_write), .codec_dac_left(z_dac_l),
        .codec_dac_right(z_dac_r));

    // Frame-level reference model.
    logic [31:0] m_txq[$];
    logic [31:0] m_rxq[$];
    logic [23:0] m_last_l, m_last_r, m_dh_l, m_dh_r, m_dz_l, m_dz_r;
    logic        m_ovf, m_unf;
    logic [15:0] m_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] tx;
        logic [23:0] al, ar;
        logic [23:0] exp_dl, exp_dr;
        logic [31:0] exp_rx;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pad16(input logic [15:0] s);
        return {s, 8'h00};
    endfunction

    function automatic logic [15:0] trunc16(input logic [23:0] a);
        return a[23:8];
    endfunction

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_last_l = '0; m_last_r = '0;
        m_dh_l = '0; m_dh_r = '0; m_dz_l = '0; m_dz_r = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_count = '0;
    endtask

    task automatic model_start(input bit lb, input bit push, input logic [31:0] txd, input bit clr);
        bit          was_full  = (m_txq.size() == DEPTH);
        bit          was_empty = (m_txq.size() == 0);
        bit          unf_set   = 1'b0;
        logic [31:0] f;
        if (lb) begin
            m_dh_l = pad16(trunc16(m_last_l)); m_dh_r = pad16(trunc16(m_last_r));
            m_dz_l = m_dh_l; m_dz_r = m_dh_r;
        end else if (!was_empty) begin
            f = m_txq.pop_front();
            m_dh_l = pad16(f[31:16]); m_dh_r = pad16(f[15:0]);
            m_dz_l = m_dh_l; m_dz_r = m_dh_r;
        end else begin
            unf_set = 1'b1;
            m_dz_l = '0; m_dz_r = '0;
        end
        if (push && !was_full) m_txq.push_back(txd);
        if (unf_set) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        if (clr) m_ovf = 1'b0;
    endtask

    task automatic model_xfer(input logic [23:0] al, input logic [23:0] ar, input bit pop);
        bit was_full  = (m_rxq.size() == DEPTH);
        bit was_empty = (m_rxq.size() == 0);
        m_last_l = al; m_last_r = ar;
        if (pop && !was_empty) void'(m_rxq.pop_front());
        if (!was_full) m_rxq.push_back({trunc16(al), trunc16(ar)});
        else m_ovf = 1'b1;
        m_count = m_count + 16'd1;
    endtask

    task automatic check_state(input string t);
        check({t, ".tx_ready"}, 48'(h_tx_ready), 48'(m_txq.size() < DEPTH));
        check({t, ".tx_level"}, 48'(h_tx_level), 48'(m_txq.size()));
        check({t, ".rx_valid"}, 48'(h_rx_valid), 48'(m_rxq.size() != 0));
        check({t, ".rx_level"}, 48'(h_rx_level), 48'(m_rxq.size()));
        if (m_rxq.size() != 0) begin
            check({t, ".rx_data"},   48'(h_rx_data), 48'(m_rxq[0]));
            check({t, ".z_rx_data"}, 48'(z_rx_data), 48'(m_rxq[0]));
        end
        check({t, ".overflow"}, 48'(h_overflow), 48'(m_ovf));
        check({t, ".underrun"}, 48'(h_underrun), 48'(m_unf));
        check({t, ".count"},    48'(h_count),    48'(m_count));
        check({t, ".dac_hold"}, {h_dac_l, h_dac_r}, {m_dh_l, m_dh_r});
        check({t, ".dac_zero"}, {z_dac_l, z_dac_r}, {m_dz_l, m_dz_r});
        check({t, ".z_flags"},  48'({z_overflow, z_underrun, z_tx_ready, z_rx_valid}),
              48'({m_ovf, m_unf, m_txq.size() < DEPTH, m_rxq.size() != 0}));
        check({t, ".z_levels"}, 48'({z_tx_level, z_rx_level, z_count}),
              48'({LW'(m_txq.size()), LW'(m_rxq.size()), m_count}));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; rd_rdy = 1'b0; wr_rdy = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
        loopback = 1'b0; clear_flags = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_tx(input logic [31:0] d);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d;
        @(posedge clk);
        if (m_txq.size() < DEPTH) m_txq.push_back(d);
        #1 check_state("push");
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        if (m_rxq.size() != 0) void'(m_rxq.pop_front());
        #1 check_state("pop");
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clear_cycle();
        @(negedge clk);
        clear_flags = 1'b1;
        @(posedge clk);
        m_unf = 1'b0; m_ovf = 1'b0;
        #1 check("clear.underrun", 48'(h_underrun), 48'(0));
        check("clear.overflow", 48'(h_overflow), 48'(0));
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    task automatic frame(input logic [23:0] al, input logic [23:0] ar, input bit lb,
                         input bit push, input logic [31:0] txd, input bit pop, input bit clr);
        @(negedge clk);
        rd_rdy = 1'b1; wr_rdy = 1'b1; loopback = lb; tx_valid = push; tx_data = txd;
        clear_flags = clr; adc_l = al; adc_r = ar;
        @(posedge clk);
        model_start(lb, push, txd, clr);
        #1 check("xfer.strobes", 48'({h_read, h_write, h_strobe, z_read, z_write, z_strobe}), 48'(6'h3F));
        check_state("start");
        @(negedge clk);
        rd_rdy = 1'b0; wr_rdy = 1'b0; tx_valid = 1'b0; clear_flags = 1'b0; rx_ready = pop;
        loopback = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_xfer(al, ar, pop);
        #1 check("after.strobes", 48'({h_read, h_write, h_strobe, z_strobe}), 48'(0));
        check_state("xfer");
        @(negedge clk);
        rx_ready = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int n_str;
        tbl[0] = '{32'h1234ABCD, 24'h7FFFFF, 24'h800001, 24'h123400, 24'hABCD00, 32'h7FFF8000};
        tbl[1] = '{32'h00FFFF00, 24'h000000, 24'hFFFFFF, 24'h00FF00, 24'hFF0000, 32'h0000FFFF};
        tbl[2] = '{32'h80000001, 24'h123456, 24'hABCDEF, 24'h800000, 24'h000100, 32'h1234ABCD};
        tbl[3] = '{32'hFFFFFFFF, 24'h0000FF, 24'hFF0000, 24'hFFFF00, 24'hFFFF00, 32'h0000FF00};

        // Reset values.
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.outputs", 48'({h_tx_ready, h_rx_valid, h_overflow, h_underrun, h_read, h_write, h_strobe}),
              48'(7'b1000000));
        check("reset.counters", 48'({h_count, h_tx_level, h_rx_level}), 48'(0));
        check("reset.dac", {h_dac_l, h_dac_r}, 48'(0));
        rst = 1'b0;

        // Table: push one frame, transfer it, compare DAC and RX against hand values.
        for (int i = 0; i < 4; i++) begin
            push_tx(tbl[i].tx);
            check("tbl.tx_level_before", 48'(h_tx_level), 48'(1));
            frame(tbl[i].al, tbl[i].ar, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            check("tbl.dac", {h_dac_l, h_dac_r}, {tbl[i].exp_dl, tbl[i].exp_dr});
            check("tbl.rx_data", 48'(h_rx_data), 48'(tbl[i].exp_rx));
            check("tbl.tx_level_after", 48'(h_tx_level), 48'(0));
            pop_rx();
        end

        // Readies held high: one transfer only; a dip permits the second.
        reset_dut();
        @(negedge clk);
        rd_rdy = 1'b1; wr_rdy = 1'b1; adc_l = 24'h0A0B0C; adc_r = 24'h0D0E0F; n_str = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            if (c == 0) model_start(1'b0, 1'b0, '0, 1'b0);
            if (c == 1) model_xfer(adc_l, adc_r, 1'b0);
            #1 if (h_strobe) n_str++;
        end
        check("hold.one_xfer", 48'(n_str), 48'(1));
        @(negedge clk); wr_rdy = 1'b0;
        @(negedge clk); wr_rdy = 1'b1; n_str = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            if (c == 0) model_start(1'b0, 1'b0, '0, 1'b0);
            if (c == 1) model_xfer(adc_l, adc_r, 1'b0);
            #1 if (h_strobe) n_str++;
        end
        check("dip.second_xfer", 48'(n_str), 48'(1));
        @(negedge clk); rd_rdy = 1'b0; wr_rdy = 1'b0;
        @(posedge clk);
        #1 check("dip.frame_count", 48'(h_count), 48'(2));
        check_state("dip");
        while (m_rxq.size() != 0) pop_rx();
        clear_cycle();

        // Underrun: hold instance repeats the last frame, zero instance sends zeros.
        push_tx(32'h11112222);
        frame(24'h010101, 24'h020202, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("unf.none_yet", 48'(h_underrun), 48'(0));
        frame(24'h030303, 24'h040404, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("unf.hold_dac", {h_dac_l, h_dac_r}, {24'h111100, 24'h222200});
        check("unf.zero_dac", {z_dac_l, z_dac_r}, 48'(0));
        check("unf.flag", 48'({h_underrun, z_underrun}), 48'(2'b11));
        clear_cycle();
        frame(24'h050505, 24'h060606, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("unf.error_beats_clear", 48'(h_underrun), 48'(1));
        clear_cycle();
        while (m_rxq.size() != 0) pop_rx();

        // Overflow: 17 frames into a 16-deep RX FIFO with no reader.
        frame(24'h7FFFFF, 24'h800001, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("ovf.first_rx", 48'(h_rx_data), 48'(32'h7FFF8000));
        for (int i = 1; i < 17; i++)
            frame(24'($urandom), 24'($urandom), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("ovf.rx_level", 48'(h_rx_level), 48'(16));
        check("ovf.flag", 48'(h_overflow), 48'(1));
        check("ovf.head_kept", 48'(h_rx_data), 48'(32'h7FFF8000));
        clear_cycle();
        while (m_rxq.size() != 0) pop_rx();

        // Loopback: DAC carries the previous frame's ADC, TX FIFO untouched.
        push_tx(32'hAAAA5555);
        frame(24'h123456, 24'h654321, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        frame(24'h0F0F0F, 24'hF0F0F0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("lb.dac", {h_dac_l, h_dac_r}, {24'h123400, 24'h654300});
        check("lb.tx_level", 48'(h_tx_level), 48'(1));
        frame(24'h000000, 24'h000000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("lb.off_dac", {h_dac_l, h_dac_r}, {24'hAAAA00, 24'h555500});
        while (m_rxq.size() != 0) pop_rx();

        // Frame counter wrap.
        @(negedge clk);
        force dut_h.r_frame_count = 16'hFFFF;
        force dut_z.r_frame_count = 16'hFFFF;
        #1;
        release dut_h.r_frame_count;
        release dut_z.r_frame_count;
        m_count = 16'hFFFF;
        frame(24'h111111, 24'h222222, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("wrap.count", 48'(h_count), 48'(0));
        pop_rx();
        clear_cycle();

        // Randomised mix of pushes, pops and frames.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: push_tx($urandom);
                1: pop_rx();
                2: clear_cycle();
                default: frame(24'($urandom), 24'($urandom), ($urandom_range(0, 3) == 0),
                               1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                               ($urandom_range(0, 7) == 0));
            endcase
        end

        // Reset during the transfer cycle with three entries in each FIFO.
        reset_dut();
        for (int i = 0; i < 3; i++) frame(24'($urandom), 24'($urandom), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_tx($urandom);
        check("rst.levels_before", 48'({h_tx_level, h_rx_level}), 48'({5'd3, 5'd3}));
        @(negedge clk);
        loopback = 1'b0; rd_rdy = 1'b1; wr_rdy = 1'b1;
        @(posedge clk);
        #1 check("rst.write_high", 48'(h_write), 48'(1));
        #1 rst = 1'b1;
        #1 check("rst.strobes_drop", 48'({h_read, h_write, h_strobe}), 48'(0));
        check("rst.levels", 48'({h_tx_level, h_rx_level}), 48'(0));
        @(negedge clk);
        rd_rdy = 1'b0; wr_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 check("rst.flags", 48'({h_overflow, h_underrun}), 48'(0));
        check_state("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/audio_stream_bridge.md
# audio_stream_bridge

Buffered, parametrised stereo sample bridge between user logic and the CODEC core (`audio_codec`). Replaces the bare per-frame `advance` strobe with valid/ready streams backed by TX and RX FIFOs, and adds configurable sample width, underrun policy, overflow/underrun flags, a frame counter and a loopback mode. Sits beside `audio_and_video_config` under the board top level.

## Interface
- `SAMPLE_W`, default 24: user sample width per channel, 8..24.
- `FIFO_DEPTH`, default 16: entries per FIFO, power of two, ≥2.
- `UNDERRUN_HOLD`, default 0: on TX underrun, 1 = resend last frame, 0 = send zeros.
- `CLOCK_50`  in  1  system clock. All logic is on this one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_valid` / `tx_ready`  in / out  1  TX handshake. `tx_ready` = TX FIFO not full.
- `tx_data`  in  2*SAMPLE_W  `{left,right}`.
- `rx_valid` / `rx_ready`  out / in  1  RX handshake. `rx_valid` = RX FIFO not empty.
- `rx_data`  out  2*SAMPLE_W  `{left,right}`, show-ahead.
- `loopback`  in  1  DAC is fed from the previous ADC frame; TX FIFO is not popped.
- `clear_flags`  in  1  one-cycle clear of the sticky flags.
- `overflow`, `underrun`  out  1  sticky error flags.
- `frame_strobe`  out  1  one-cycle pulse per codec frame.
- `frame_count`  out  16  frames transferred, wraps 0xFFFF→0.
- `tx_level`, `rx_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `codec_read_ready`, `codec_write_ready`  in  1  from codec core.
- `codec_adc_left`, `codec_adc_right`  in  24  ADC data from codec core.
- `codec_read`, `codec_write`  out  1  transfer pulses to codec core.
- `codec_dac_left`, `codec_dac_right`  out  24  DAC data to codec core.

## Operation
- FSM states are IDLE, XFER and WAIT_LOW.
- IDLE → XFER when both codec ready inputs are high. On this transition:
  - Load the DAC registers from the TX FIFO head and pop it (normal mode, FIFO non-empty).
  - If the TX FIFO is empty: load per `UNDERRUN_HOLD` and set `underrun`.
  - If `loopback` = 1: load the DAC registers from `last_adc` and do not pop.
- XFER (exactly one cycle):
  - `codec_read` = `codec_write` = `frame_strobe` = 1.
  - Capture the codec ADC data into `last_adc`.
  - Push the truncated sample into the RX FIFO if it is not full; otherwise drop the frame and set `overflow`.
  - Increment `frame_count`.
  - Always go to WAIT_LOW.
- WAIT_LOW → IDLE when either codec ready input is low. This prevents a second transfer within one frame.
- Width conversion:
  - DAC = `{sample, (24-SAMPLE_W) zeros}`.
  - RX sample = ADC[23 -: SAMPLE_W] (truncate LSBs, no rounding).
- FIFO push/pop use the registered full/empty flags. A user push to a full TX FIFO is ignored, because `tx_ready` = 0 forbids it.
- Simultaneous push and pop on the same FIFO are legal: level is unchanged and data order is preserved.
- `clear_flags` in the same cycle as a new error: the error wins (flag stays 1).
- `loopback` is sampled only on the IDLE→XFER transition. Toggling it mid-frame has no effect until the next frame.

## Timing
- Both codec ready inputs high at cycle N (in IDLE):
  - Cycle N+1: XFER, with DAC data stable and the strobes asserted.
  - Cycle N+2: RX sample visible on `rx_data` / `rx_valid`.
- TX latency: `tx_data` accepted at cycle M is sent at the first IDLE→XFER after M.
- Loopback latency is exactly one frame.
- Reset values (async):
  - FSM = IDLE; both FIFOs empty.
  - `codec_read`, `codec_write`, `frame_strobe`, `overflow`, `underrun`, `rx_valid` = 0.
  - `codec_dac_*`, `last_adc`, `frame_count`, levels = 0.
  - `tx_ready` = 1.
- Reset asserted mid-XFER: the strobes drop immediately (asynchronous), the frame is lost and FIFO contents are discarded.

## Structure
- Package `audio_stream_pkg`: `CODEC_W` = 24, the state enum `{IDLE, XFER, WAIT_LOW}`, and pad/truncate functions.
- Sub-module `audio_sync_fifo` (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level; async reset), instantiated for TX and RX. Expected size is about 80 lines; the top is about 200.

## Test plan
- SAMPLE_W=16. Push `{0x1234,0xABCD}`, then raise both ready inputs:
  - `codec_dac_left` = 0x123400 and `codec_dac_right` = 0xABCD00 during the single-cycle write pulse.
  - `tx_level` goes 1→0.
- SAMPLE_W=16, ADC = 0x7FFFFF / 0x800001, `rx_ready` = 0 held: `rx_data` = `{0x7FFF,0x8000}` at N+2.
  - After 17 frames with DEPTH=16: `rx_level` = 16, `overflow` = 1, and the first entry is unchanged.
- TX FIFO empty, UNDERRUN_HOLD=1, previous frame 0x111111/0x222222: the frame is resent and `underrun` = 1.
  - `clear_flags` clears `underrun` the next cycle.
  - Repeat with UNDERRUN_HOLD=0: the DAC sends 0/0.
- Hold both ready inputs high for 10 cycles: exactly one XFER.
  - Drop either ready for one cycle, then raise it again: a second XFER occurs and `frame_count` = 2.
- `loopback` = 1, ADC frames A then B: the DAC sends A (padded form of the captured 24-bit value) on the second frame and `tx_level` does not change.
  - Preset `frame_count` to 0xFFFF: it wraps to 0 and `frame_strobe` still pulses.
- Assert `reset` in the XFER cycle with 3 entries in each FIFO: `codec_write` falls within the same cycle, levels read 0, and flags read 0 after release.
